mac_lane_pe: RTL and testbench

Parametrised multiply-accumulate processing element for the systolic array. It replaces the fixed three-lane, eight-accumulator MAC with a configurable lane count, accumulator depth and operand width. It adds a two-stage pipeline, an independent accumulator read port, a valid-tagged activation pass-through and optional saturating accumulation. One instance sits at each array node: activations flow right through `a_out`, and results drain through `acc_out` or the read port.

---
 rtl/mac_lane_pe_if.sv | 52 +++++
 rtl/mac_lane_pe.sv | 230 +++++++++++++++++++++++
 tb/tb_mac_lane_pe.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mac_lane_pe_if.sv
// mac_lane_pe_if
//   Bundles the data/control bus of one mac_lane_pe array node.
//   master modport: the side that drives operands and requests (array
//   controller or neighbouring node); slave modport: the PE itself.
//
//   Request side (master -> slave):
//     valid_ctrl [NUM_LANES]        per-lane valid, any bit requests a MAC
//     a_in       [NUM_LANES*DATA_W] packed signed activations, lane k at k*DATA_W
//     weight     [DATA_W]           signed weight
//     acc_sel    [SEL_W]            target accumulator
//     clear                         zero accumulators, flush pipeline
//     rd_en / rd_sel                accumulator read request
//   Response side (slave -> master):
//     a_out / valid_ctrl_out        one-cycle pass-through of a_in / valid_ctrl
//     acc_out / valid_out           updated accumulator value and its strobe
//     rd_data / rd_valid            read-port data and its strobe
//     sat_flag                      sticky overflow indicator
interface mac_lane_pe_if #(
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 16,
  parameter int NUM_LANES = 3,
  parameter int NUM_ACC   = 8,
  parameter int SEL_W     = $clog2(NUM_ACC)
) ();

  logic [NUM_LANES-1:0]        valid_ctrl;
  logic [NUM_LANES*DATA_W-1:0] a_in;
  logic [DATA_W-1:0]           weight;
  logic [SEL_W-1:0]            acc_sel;
  logic                        clear;
  logic                        rd_en;
  logic [SEL_W-1:0]            rd_sel;

  logic [NUM_LANES*DATA_W-1:0] a_out;
  logic [NUM_LANES-1:0]        valid_ctrl_out;
  logic [ACC_W-1:0]            acc_out;
  logic                        valid_out;
  logic [ACC_W-1:0]            rd_data;
  logic                        rd_valid;
  logic                        sat_flag;

  modport master (
    output valid_ctrl, a_in, weight, acc_sel, clear, rd_en, rd_sel,
    input  a_out, valid_ctrl_out, acc_out, valid_out, rd_data, rd_valid, sat_flag
  );

  modport slave (
    input  valid_ctrl, a_in, weight, acc_sel, clear, rd_en, rd_sel,
    output a_out, valid_ctrl_out, acc_out, valid_out, rd_data, rd_valid, sat_flag
  );

endinterface

// File: rtl/mac_lane_pe.sv
// mac_lane_pe
//   Multiply-accumulate processing element for one systolic array node.
//   The lowest-indexed valid lane is multiplied by the weight (stage 1) and
//   added into the selected accumulator (stage 2): 2-cycle latency, one MAC
//   per cycle. An independent read port returns any accumulator one cycle
//   after the request; activations and lane valids are passed right with
//   one cycle of delay.
//
//   Ports:
//     clk    sole clock, rising edge
//     rst_n  synchronous active-low reset (clears everything)
//     bus    mac_lane_pe_if.slave (operands, clear, read port, results)
//
//   Build option:
//     MAC_SAT_EN  defined   -> accumulation saturates to the ACC_W signed
//                              range and sat_flag records any clamp
//                 undefined -> accumulation wraps, sat_flag is tied to 0
module mac_lane_pe #(
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 16,
  parameter int NUM_LANES = 3,
  parameter int NUM_ACC   = 8,
  parameter int SEL_W     = $clog2(NUM_ACC)
) (
  input  logic           clk,
  input  logic           rst_n,
  mac_lane_pe_if.slave   bus
);

  localparam int PROD_W = 2 * DATA_W;

  // ---------------------------------------------------------------------
  // Lane select: lowest-indexed valid lane wins
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] lane_val [NUM_LANES];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign lane_val[gi] = bus.a_in[gi*DATA_W +: DATA_W];
    end
  endgenerate

  logic [DATA_W-1:0] lane_pick;

  // Scan from the top lane down so the lowest set bit overrides last.
  always_comb begin
    lane_pick = '0;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      if (bus.valid_ctrl[k]) begin
        lane_pick = lane_val[k];
      end
    end
  end

  // Both operands sign-extended to the product width; the low PROD_W bits
  // of the full-width multiply are then the exact signed product.
  logic [PROD_W-1:0] lane_ext;
  logic [PROD_W-1:0] weight_ext;

  assign lane_ext   = {{DATA_W{lane_pick[DATA_W-1]}}, lane_pick};
  assign weight_ext = {{DATA_W{bus.weight[DATA_W-1]}}, bus.weight};

  // ---------------------------------------------------------------------
  // Stage 1: product, target index, issue bit
  // ---------------------------------------------------------------------
  logic              issue1_q, issue1_d;
  logic [PROD_W-1:0] prod1_q,  prod1_d;
  logic [SEL_W-1:0]  sel1_q,   sel1_d;

  always_comb begin
    // An op presented together with clear is dropped.
    issue1_d = (|bus.valid_ctrl) && !bus.clear;
    prod1_d  = lane_ext * weight_ext;
    sel1_d   = bus.acc_sel;
  end

  // ---------------------------------------------------------------------
  // Stage 2: accumulate
  // ---------------------------------------------------------------------
  logic [ACC_W-1:0] acc_q [NUM_ACC];
  logic [ACC_W-1:0] acc_d [NUM_ACC];
  logic [ACC_W-1:0] acc_cur;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] sum;

  generate
    if (ACC_W > PROD_W) begin : g_prod_sext
      assign prod_ext = {{(ACC_W-PROD_W){prod1_q[PROD_W-1]}}, prod1_q};
    end else begin : g_prod_same
      assign prod_ext = prod1_q;
    end
  endgenerate

  // The previous op has already committed to acc_q, so back-to-back MACs
  // to the same accumulator read a current value without forwarding.
  assign acc_cur = acc_q[sel1_q];

`ifdef MAC_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0] sum_wide;
  logic           ovf;

  // One guard bit: the two top bits of the sum disagree exactly on overflow,
  // and the guard bit gives the true sign for the clamp direction.
  always_comb begin
    sum_wide = {acc_cur[ACC_W-1], acc_cur} + {prod_ext[ACC_W-1], prod_ext};
    ovf      = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    if (!ovf) begin
      sum = sum_wide[ACC_W-1:0];
    end else if (sum_wide[ACC_W]) begin
      sum = ACC_MIN;
    end else begin
      sum = ACC_MAX;
    end
  end
`else
  assign sum = acc_cur + prod_ext;
`endif

  // ---------------------------------------------------------------------
  // Output, read-port and pass-through registers
  // ---------------------------------------------------------------------
  logic [ACC_W-1:0]            acc_out_q,        acc_out_d;
  logic                        valid_out_q,      valid_out_d;
  logic [ACC_W-1:0]            rd_data_q,        rd_data_d;
  logic                        rd_valid_q,       rd_valid_d;
  logic [NUM_LANES*DATA_W-1:0] a_out_q,          a_out_d;
  logic [NUM_LANES-1:0]        valid_ctrl_out_q, valid_ctrl_out_d;
`ifdef MAC_SAT_EN
  logic                        sat_flag_q,       sat_flag_d;
`endif

  always_comb begin
    acc_d       = acc_q;
    acc_out_d   = acc_out_q;
    valid_out_d = 1'b0;
`ifdef MAC_SAT_EN
    sat_flag_d  = sat_flag_q;
`endif

    // clear beats the in-flight stage-2 op, which is simply discarded.
    if (bus.clear) begin
      for (int k = 0; k < NUM_ACC; k++) begin
        acc_d[k] = '0;
      end
      acc_out_d  = '0;
`ifdef MAC_SAT_EN
      sat_flag_d = 1'b0;
`endif
    end else if (issue1_q) begin
      acc_d[sel1_q] = sum;
      acc_out_d     = sum;
      valid_out_d   = 1'b1;
`ifdef MAC_SAT_EN
      if (ovf) begin
        sat_flag_d = 1'b1;
      end
`endif
    end

    // Reads see the pre-edge accumulator, so a same-edge stage-2 write is
    // not visible; a read alongside clear returns the cleared value.
    rd_valid_d = bus.rd_en;
    rd_data_d  = rd_data_q;
    if (bus.rd_en) begin
      rd_data_d = bus.clear ? '0 : acc_q[bus.rd_sel];
    end

    a_out_d          = bus.a_in;
    valid_ctrl_out_d = bus.valid_ctrl;
  end

  generate
    for (gi = 0; gi < NUM_ACC; gi++) begin : g_acc
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          acc_q[gi] <= '0;
        end else begin
          acc_q[gi] <= acc_d[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issue1_q         <= 1'b0;
      prod1_q          <= '0;
      sel1_q           <= '0;
      acc_out_q        <= '0;
      valid_out_q      <= 1'b0;
      rd_data_q        <= '0;
      rd_valid_q       <= 1'b0;
      a_out_q          <= '0;
      valid_ctrl_out_q <= '0;
`ifdef MAC_SAT_EN
      sat_flag_q       <= 1'b0;
`endif
    end else begin
      issue1_q         <= issue1_d;
      prod1_q          <= prod1_d;
      sel1_q           <= sel1_d;
      acc_out_q        <= acc_out_d;
      valid_out_q      <= valid_out_d;
      rd_data_q        <= rd_data_d;
      rd_valid_q       <= rd_valid_d;
      a_out_q          <= a_out_d;
      valid_ctrl_out_q <= valid_ctrl_out_d;
`ifdef MAC_SAT_EN
      sat_flag_q       <= sat_flag_d;
`endif
    end
  end

  assign bus.acc_out        = acc_out_q;
  assign bus.valid_out      = valid_out_q;
  assign bus.rd_data        = rd_data_q;
  assign bus.rd_valid       = rd_valid_q;
  assign bus.a_out          = a_out_q;
  assign bus.valid_ctrl_out = valid_ctrl_out_q;
`ifdef MAC_SAT_EN
  assign bus.sat_flag       = sat_flag_q;
`else
  assign bus.sat_flag       = 1'b0;
`endif

endmodule

// File: tb/tb_mac_lane_pe.sv
// tb_mac_lane_pe
//   Directed bench for mac_lane_pe at default parameters. Expected MAC and
//   read results are queued with the cycle they must appear in; a negedge
//   monitor pops and compares them as the DUT strobes valid_out / rd_valid.
module tb_mac_lane_pe;

  localparam int DATA_W    = 8;
  localparam int ACC_W     = 16;
  localparam int NUM_LANES = 3;
  localparam int NUM_ACC   = 8;
  localparam int SEL_W     = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mac_lane_pe_if #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .NUM_LANES(NUM_LANES),
    .NUM_ACC(NUM_ACC), .SEL_W(SEL_W)
  ) bus ();

  mac_lane_pe #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .NUM_LANES(NUM_LANES),
    .NUM_ACC(NUM_ACC), .SEL_W(SEL_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int cyc;
    int val;
  } exp_t;

  exp_t mac_exp[$];
  exp_t rd_exp[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic signed [31:0] obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Scoreboard monitor: every strobe must match the head of its queue,
  // both in value and in the cycle it was promised for.
  always @(negedge clk) begin
    if (bus.valid_out === 1'b1) begin
      if (mac_exp.size() == 0) begin
        check("unexpected_valid_out", bus.valid_out, 0);
      end else begin
        exp_t e;
        e = mac_exp.pop_front();
        $display("mac  cyc=%0d acc_out=%0d expected=%0d", cyc, $signed(bus.acc_out), e.val);
        check("acc_out", $signed(bus.acc_out), e.val);
        check("acc_out_cycle", cyc, e.cyc);
      end
    end
    if (bus.rd_valid === 1'b1) begin
      if (rd_exp.size() == 0) begin
        check("unexpected_rd_valid", bus.rd_valid, 0);
      end else begin
        exp_t e;
        e = rd_exp.pop_front();
        $display("read cyc=%0d rd_data=%0d expected=%0d", cyc, $signed(bus.rd_data), e.val);
        check("rd_data", $signed(bus.rd_data), e.val);
        check("rd_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.valid_ctrl = '0;
    bus.a_in       = '0;
    bus.weight     = '0;
    bus.acc_sel    = '0;
    bus.clear      = 1'b0;
    bus.rd_en      = 1'b0;
    bus.rd_sel     = '0;
  endtask

  task automatic mac(input logic [2:0] vc, input int a0, input int a1, input int a2,
                     input int w, input int sel, input bit push, input int exp_v);
    bus.valid_ctrl = vc;
    bus.a_in       = {a2[7:0], a1[7:0], a0[7:0]};
    bus.weight     = w[7:0];
    bus.acc_sel    = sel[2:0];
    if (push) mac_exp.push_back('{cyc + 2, exp_v});
    tick();
    bus.valid_ctrl = '0;
  endtask

  task automatic rd(input int sel, input int exp_v);
    bus.rd_en  = 1'b1;
    bus.rd_sel = sel[2:0];
    rd_exp.push_back('{cyc + 1, exp_v});
    tick();
    bus.rd_en  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int ovf_exp [3];
    int final0;
    int sat_exp;

    // 1. Reset, then every accumulator reads back 0
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("rst_acc_out",        $signed(bus.acc_out), 0);
    check("rst_valid_out",      bus.valid_out, 0);
    check("rst_rd_data",        $signed(bus.rd_data), 0);
    check("rst_rd_valid",       bus.rd_valid, 0);
    check("rst_a_out",          bus.a_out, 0);
    check("rst_valid_ctrl_out", bus.valid_ctrl_out, 0);
    check("rst_sat_flag",       bus.sat_flag, 0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < NUM_ACC; i++) rd(i, 0);
    repeat (2) tick();

    // 2. Lane priority: lane 0 holds data but is not valid, lane 1 wins
    mac(3'b110, 9, 5, 7, 3, 2, 1'b1, 15);
    repeat (3) tick();
    rd(2, 15);
    tick();

    // 3. Back-to-back into acc 1
    for (int k = 1; k <= 4; k++) mac(3'b001, -4, 0, 0, 10, 1, 1'b1, -40 * k);
    repeat (3) tick();
    rd(1, -160);
    tick();

    // 4. Overflow into acc 0
`ifdef MAC_SAT_EN
    ovf_exp = '{16129, 32258, 32767};
    sat_exp = 1;
`else
    ovf_exp = '{16129, 32258, -17149};
    sat_exp = 0;
`endif
    final0 = ovf_exp[2];
    for (int k = 0; k < 3; k++) mac(3'b001, 127, 0, 0, 127, 0, 1'b1, ovf_exp[k]);
    repeat (3) tick();
    @(negedge clk);
    check("ovf_sat_flag", bus.sat_flag, sat_exp);
    rd(0, final0);
    tick();

    // 5. Clear mid-pipeline; the op and read in the clear cycle see nothing
    mac(3'b001, 11, 0, 0, 2, 4, 1'b0, 0);
    bus.clear      = 1'b1;
    bus.valid_ctrl = 3'b101;
    bus.a_in       = {8'd33, 8'd22, 8'd11};
    bus.weight     = 8'd1;
    bus.rd_en      = 1'b1;
    bus.rd_sel     = 3'd1;
    rd_exp.push_back('{cyc + 1, 0});
    tick();
    idle();
    @(negedge clk);
    check("clr_a_out",          bus.a_out, 24'h21160B);
    check("clr_valid_ctrl_out", bus.valid_ctrl_out, 3'b101);
    check("clr_acc_out",        $signed(bus.acc_out), 0);
    check("clr_sat_flag",       bus.sat_flag, 0);
    repeat (3) tick();
    for (int i = 0; i < NUM_ACC; i++) rd(i, 0);
    tick();

    // 6. Same-edge read/write on acc 3
    mac(3'b001, 4, 0, 0, 5, 3, 1'b1, 20);
    repeat (3) tick();
    mac(3'b001, 5, 0, 0, 1, 3, 1'b1, 25);
    rd(3, 20);
    repeat (2) tick();
    rd(3, 25);
    tick();

    // Reset with two ops in flight
    mac(3'b001, 3, 0, 0, 3, 5, 1'b0, 0);
    bus.valid_ctrl = 3'b001;
    bus.a_in       = {8'd0, 8'd0, 8'd2};
    bus.weight     = 8'd2;
    bus.acc_sel    = 3'd3;
    rst_n          = 1'b0;
    tick();
    idle();
    tick();
    @(negedge clk);
    check("rst2_valid_out", bus.valid_out, 0);
    check("rst2_acc_out",   $signed(bus.acc_out), 0);
    check("rst2_a_out",     bus.a_out, 0);
    rst_n = 1'b1;
    repeat (4) tick();
    for (int i = 0; i < NUM_ACC; i++) rd(i, 0);
    repeat (3) tick();

    check("mac_queue_left", mac_exp.size(), 0);
    check("rd_queue_left",  rd_exp.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
